// File: rtl/lcd_sequencer.sv
// Byte-level HD44780 4-bit sequencer: power-up init, then byte writes split into nibbles.
// Latency: accept-to-first-nibble 1 cycle; each step ends with its execution delay before ready.
// Backpressure: req_ready is high only in IDLE; the nibble side waits on xfer_done (with timeout).
module lcd_sequencer #(
    parameter int unsigned FREQ            = 50000000,
    parameter int unsigned POWERUP_US      = 20000,
    parameter int unsigned XFER_TIMEOUT_US = 1000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        req_valid,
    input  logic        req_rs,
    input  logic [7:0]  req_byte,
    output logic        req_ready,
    output logic        init_done,
    output logic        err,
    output logic        xfer_send,
    output logic [3:0]  xfer_nibble,
    output logic        xfer_rs,
    output logic [20:0] xfer_delay,
    input  logic        xfer_done
);

    localparam int unsigned T1US = FREQ / 1000000;

    // Terminal counts: the counter restarts at 0 on every state entry, so a
    // phase of N cycles ends when the counter reads N-1.
    localparam logic [23:0] PWR_LAST = 24'(POWERUP_US * T1US - 1);
    localparam logic [23:0] GAP_LAST = 24'(T1US - 1);
    localparam logic [23:0] TO_LAST  = 24'(XFER_TIMEOUT_US * T1US - 1);

    localparam logic [20:0] DLY_LONG  = 21'(2000 * T1US);
    localparam logic [20:0] DLY_SHORT = 21'(50 * T1US);
    localparam logic [20:0] DLY_100   = 21'(100 * T1US);
    localparam logic [20:0] DLY_4100  = 21'(4100 * T1US);

    typedef enum logic [3:0] {
        PWR_WAIT,
        LOAD,
        SEND_HI,
        WAIT_HI,
        GAP,
        SEND_LO,
        WAIT_LO,
        POST,
        IDLE
    } state_t;

    // Init ROM: bytes of the power-up sequence.
    function automatic logic [7:0] rom_byte(input logic [2:0] s);
        logic [7:0] b;
        case (s)
            3'd0, 3'd1, 3'd2: b = 8'h30;
            3'd3:             b = 8'h20;
            3'd4:             b = 8'h28;
            3'd5:             b = 8'h0C;
            3'd6:             b = 8'h01;
            default:          b = 8'h06;
        endcase
        return b;
    endfunction

    // The first four steps are the 8-bit-mode wake-up: only the upper nibble is sent.
    function automatic logic rom_single(input logic [2:0] s);
        return ~s[2];
    endfunction

    // Init ROM: execution delay of each step, in cycles.
    function automatic logic [20:0] rom_delay(input logic [2:0] s);
        logic [20:0] d;
        case (s)
            3'd0:             d = DLY_4100;
            3'd1, 3'd2, 3'd3: d = DLY_100;
            3'd6:             d = DLY_LONG;
            default:          d = DLY_SHORT;
        endcase
        return d;
    endfunction

    // Clear (0x01) and home (0x02/0x03) are the slow commands; data bytes are always fast.
    function automatic logic [20:0] user_delay(input logic rs, input logic [7:0] b);
        logic slow;
        slow = !rs && ((b == 8'h01) || (b == 8'h02) || (b == 8'h03));
        return slow ? DLY_LONG : DLY_SHORT;
    endfunction

    state_t      state_q, state_d;
    logic [2:0]  step_q, step_d;
    logic [23:0] cnt_q, cnt_d;
    logic [7:0]  byte_q, byte_d;
    logic        single_q, single_d;
    logic        req_ready_q, req_ready_d;
    logic        init_done_q, init_done_d;
    logic        err_q, err_d;
    logic        xfer_send_q, xfer_send_d;
    logic [3:0]  xfer_nibble_q, xfer_nibble_d;
    logic        xfer_rs_q, xfer_rs_d;
    logic [20:0] xfer_delay_q, xfer_delay_d;

    logic [23:0] post_last;
    logic        counting;

    assign post_last = {3'b000, xfer_delay_q} - 24'd1;
    assign counting  = (state_q == PWR_WAIT) || (state_q == WAIT_HI) || (state_q == GAP) ||
                       (state_q == WAIT_LO)  || (state_q == POST);

    // Next-state and next-output logic; outputs are derived from the next state so they register cleanly.
    always_comb begin
        state_d       = state_q;
        step_d        = step_q;
        byte_d        = byte_q;
        single_d      = single_q;
        init_done_d   = init_done_q;
        err_d         = err_q;
        xfer_nibble_d = xfer_nibble_q;
        xfer_rs_d     = xfer_rs_q;
        xfer_delay_d  = xfer_delay_q;
        cnt_d         = cnt_q;

        case (state_q)
            PWR_WAIT: begin
                if (cnt_q == PWR_LAST) begin
                    state_d = LOAD;
                    step_d  = 3'd0;
                end
            end
            LOAD: begin
                byte_d        = rom_byte(step_q);
                single_d      = rom_single(step_q);
                xfer_rs_d     = 1'b0;
                xfer_delay_d  = rom_delay(step_q);
                xfer_nibble_d = byte_d[7:4];
                state_d       = SEND_HI;
            end
            SEND_HI: begin
                state_d = WAIT_HI;
            end
            WAIT_HI: begin
                // A done landing on the expiry cycle wins: no error in that case.
                if (xfer_done || (cnt_q == TO_LAST)) begin
                    if (!xfer_done) begin
                        err_d = 1'b1;
                    end
                    state_d = single_q ? POST : GAP;
                end
            end
            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    xfer_nibble_d = byte_q[3:0];
                    state_d       = SEND_LO;
                end
            end
            SEND_LO: begin
                state_d = WAIT_LO;
            end
            WAIT_LO: begin
                if (xfer_done || (cnt_q == TO_LAST)) begin
                    if (!xfer_done) begin
                        err_d = 1'b1;
                    end
                    state_d = POST;
                end
            end
            POST: begin
                if (cnt_q == post_last) begin
                    if (init_done_q) begin
                        state_d = IDLE;
                    end else if (step_q == 3'd7) begin
                        init_done_d = 1'b1;
                        state_d     = IDLE;
                    end else begin
                        step_d  = step_q + 3'd1;
                        state_d = LOAD;
                    end
                end
            end
            IDLE: begin
                // User bytes skip LOAD: everything needed is latched here.
                if (req_valid && req_ready_q) begin
                    byte_d        = req_byte;
                    single_d      = 1'b0;
                    xfer_rs_d     = req_rs;
                    xfer_delay_d  = user_delay(req_rs, req_byte);
                    xfer_nibble_d = req_byte[7:4];
                    state_d       = SEND_HI;
                end
            end
            default: begin
                state_d = PWR_WAIT;
            end
        endcase

        if (state_d != state_q) begin
            cnt_d = 24'd0;
        end else if (counting) begin
            cnt_d = cnt_q + 24'd1;
        end

        xfer_send_d = (state_d == SEND_HI) || (state_d == SEND_LO);
        req_ready_d = (state_d == IDLE);
    end

    // Single state/output register bank with asynchronous reset.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q       <= PWR_WAIT;
            step_q        <= 3'd0;
            cnt_q         <= 24'd0;
            byte_q        <= 8'd0;
            single_q      <= 1'b0;
            req_ready_q   <= 1'b0;
            init_done_q   <= 1'b0;
            err_q         <= 1'b0;
            xfer_send_q   <= 1'b0;
            xfer_nibble_q <= 4'd0;
            xfer_rs_q     <= 1'b0;
            xfer_delay_q  <= 21'd0;
        end else begin
            state_q       <= state_d;
            step_q        <= step_d;
            cnt_q         <= cnt_d;
            byte_q        <= byte_d;
            single_q      <= single_d;
            req_ready_q   <= req_ready_d;
            init_done_q   <= init_done_d;
            err_q         <= err_d;
            xfer_send_q   <= xfer_send_d;
            xfer_nibble_q <= xfer_nibble_d;
            xfer_rs_q     <= xfer_rs_d;
            xfer_delay_q  <= xfer_delay_d;
        end
    end

    assign req_ready   = req_ready_q;
    assign init_done   = init_done_q;
    assign err         = err_q;
    assign xfer_send   = xfer_send_q;
    assign xfer_nibble = xfer_nibble_q;
    assign xfer_rs     = xfer_rs_q;
    assign xfer_delay  = xfer_delay_q;

endmodule

// File: tb/tb_lcd_sequencer.sv
// Bench for lcd_sequencer at FREQ=1MHz (1 cycle per microsecond).
// Transfer-block model answers xfer_done a configurable number of cycles after xfer_send.
// Expected schedule comes from the step table and delay rules below, not from the RTL.
module tb_lcd_sequencer;

    localparam int PWR = 20000;
    localparam int TO  = 1000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_rs = 1'b0;
    logic [7:0]  req_byte = 8'h00;
    logic        req_ready;
    logic        init_done;
    logic        err;
    logic        xfer_send;
    logic [3:0]  xfer_nibble;
    logic        xfer_rs;
    logic [20:0] xfer_delay;
    logic        xfer_done = 1'b0;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    // Init table: byte, and execution delay in microseconds; steps 0-3 send one nibble.
    int init_byte [8] = '{8'h30, 8'h30, 8'h30, 8'h20, 8'h28, 8'h0C, 8'h01, 8'h06};
    int init_dly  [8] = '{4100, 100, 100, 100, 50, 50, 2000, 50};

    lcd_sequencer #(
        .FREQ(1000000),
        .POWERUP_US(PWR),
        .XFER_TIMEOUT_US(TO)
    ) dut (
        .CLK(clk),
        .RST(rst),
        .req_valid(req_valid),
        .req_rs(req_rs),
        .req_byte(req_byte),
        .req_ready(req_ready),
        .init_done(init_done),
        .err(err),
        .xfer_send(xfer_send),
        .xfer_nibble(xfer_nibble),
        .xfer_rs(xfer_rs),
        .xfer_delay(xfer_delay),
        .xfer_done(xfer_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Transfer-block model: per-send latency from lat_q (default 5), 0 = never answer.
    int lat_q [$];
    int done_at = -1;
    int stray_at = -1;

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                done_at = -1;
            end else if (xfer_send) begin
                int l;
                l = (lat_q.size() > 0) ? lat_q.pop_front() : 5;
                done_at = (l == 0) ? -1 : cyc + l;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            xfer_done = !rst && ((cyc == done_at) || (cyc == stray_at));
        end
    end

    // xfer_send must never be high two cycles running.
    logic prev_send = 1'b0;
    initial begin
        forever begin
            @(negedge clk);
            if (xfer_send) begin
                tests++;
                assert (prev_send === 1'b0) else begin
                    fails++;
                    $error("FAIL send_twice: xfer_send high in consecutive cycles at %0d", cyc);
                end
            end
            prev_send = xfer_send;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic timeout_fail(input string tag, input int limit);
        tests++;
        fails++;
        $error("FAIL %s: event not seen within %0d cycles", tag, limit);
    endtask

    task automatic wait_send(input string tag, input int limit, output int t);
        t = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (xfer_send) begin
                t = cyc;
                break;
            end
        end
        if (t < 0) timeout_fail(tag, limit);
    endtask

    task automatic wait_ready(input string tag, input int limit, output int t);
        t = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (req_ready) begin
                t = cyc;
                break;
            end
        end
        if (t < 0) timeout_fail(tag, limit);
    endtask

    // Effective completion cycle of a nibble sent at s with model latency l.
    function automatic int eff_done(input int s, input int l);
        return (l == 0) ? s + TO : s + l;
    endfunction

    function automatic int user_dly(input logic rs, input logic [7:0] b);
        if (!rs && (b == 8'h01 || b == 8'h02 || b == 8'h03)) return 2000;
        return 50;
    endfunction

    // Init released at cycle c0: checks every nibble, its timing and the init_done edge.
    task automatic run_init(input int c0);
        int t, d, exp_t, r;
        exp_t = c0 + PWR + 1;
        d = 0;
        for (int i = 0; i < 8; i++) begin
            wait_send("init_hi", PWR + 5000, t);
            check("init_hi_time", 32'(t), 32'(exp_t));
            check("init_hi_nib", 32'(xfer_nibble), 32'(init_byte[i] >> 4));
            check("init_hi_rs", 32'(xfer_rs), 32'd0);
            check("init_delay", 32'(xfer_delay), 32'(init_dly[i]));
            check("init_no_ready", {req_ready, init_done}, 32'd0);
            d = t + 5;
            if (i >= 4) begin
                wait_send("init_lo", 1100, t);
                check("init_lo_time", 32'(t), 32'(d + 2));
                check("init_lo_nib", 32'(xfer_nibble), 32'(init_byte[i] & 15));
                d = t + 5;
            end
            exp_t = d + init_dly[i] + 2;
        end
        r = -1;
        for (int i = 0; i < 2100; i++) begin
            @(negedge clk);
            if (init_done) begin
                r = cyc;
                break;
            end
        end
        if (r < 0) timeout_fail("init_done", 2100);
        check("init_done_time", 32'(r), 32'(d + init_dly[7] + 1));
        check("init_ready", 32'(req_ready), 32'd1);
    endtask

    // Checks one accepted byte; if abort, returns right after the low-nibble send.
    task automatic expect_write(input int acc, input logic rs, input logic [7:0] b,
                                input int lhi, input int llo, input bit abort, output int tlo);
        int t, d, dl, r;
        dl = user_dly(rs, b);
        wait_send("wr_hi", 50, t);
        check("wr_hi_time", 32'(t), 32'(acc + 1));
        check("wr_hi_nib", 32'(xfer_nibble), 32'(b[7:4]));
        check("wr_rs", 32'(xfer_rs), 32'(rs));
        check("wr_delay", 32'(xfer_delay), 32'(dl));
        check("wr_busy", 32'(req_ready), 32'd0);
        d = eff_done(t, lhi);
        wait_send("wr_lo", TO + 100, t);
        check("wr_lo_time", 32'(t), 32'(d + 2));
        check("wr_lo_nib", 32'(xfer_nibble), 32'(b[3:0]));
        check("wr_lo_rs", 32'(xfer_rs), 32'(rs));
        tlo = t;
        if (!abort) begin
            d = eff_done(t, llo);
            wait_ready("wr_ready", 3200, r);
            check("wr_ready_time", 32'(r), 32'(d + dl + 1));
        end
    endtask

    task automatic do_write(input logic rs, input logic [7:0] b, input int lhi, input int llo,
                            input bit abort, output int tlo);
        int acc;
        lat_q.push_back(lhi);
        lat_q.push_back(llo);
        wait_ready("pre_ready", 3200, acc);
        req_valid = 1'b1;
        req_rs = rs;
        req_byte = b;
        acc = cyc;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_rs = ~rs;
        req_byte = 8'($urandom);
        expect_write(acc, rs, b, lhi, llo, abort, tlo);
    endtask

    initial begin
        int c0, acc, tlo;
        logic [7:0] rb;
        logic rr;

        // Requester holds 0x80 command from before init.
        req_valid = 1'b1;
        req_rs = 1'b0;
        req_byte = 8'h80;
        repeat (3) @(negedge clk);
        check("rst_outputs", {req_ready, init_done, err, xfer_send, xfer_nibble, xfer_rs, xfer_delay},
              32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        c0 = cyc;
        run_init(c0);
        check("init_err", 32'(err), 32'd0);

        // The held request is taken on the very first IDLE cycle.
        acc = cyc;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        expect_write(acc, 1'b0, 8'h80, 5, 5, 1'b0, tlo);

        do_write(1'b1, 8'h41, 5, 5, 1'b0, tlo);
        do_write(1'b0, 8'h01, 5, 5, 1'b0, tlo);
        do_write(1'b1, 8'h01, 5, 5, 1'b0, tlo);
        do_write(1'b0, 8'h03, 5, 5, 1'b0, tlo);

        // A done pulse while idle must be ignored.
        @(negedge clk);
        stray_at = cyc + 2;
        repeat (8) begin
            @(negedge clk);
            check("stray_no_send", 32'(xfer_send), 32'd0);
        end
        check("stray_ready", 32'(req_ready), 32'd1);
        stray_at = -1;

        for (int i = 0; i < 4; i++) begin
            rr = 1'($urandom_range(0, 1));
            rb = 8'($urandom_range(0, 255));
            do_write(rr, rb, $urandom_range(1, 12), $urandom_range(1, 12), 1'b0, tlo);
        end

        // Done on the very cycle the timeout expires counts as done.
        do_write(1'b1, 8'h5A, TO, 5, 1'b0, tlo);
        check("edge_no_err", 32'(err), 32'd0);

        // Missing done on the low nibble: error, then normal completion.
        do_write(1'b0, 8'h0C, 5, 0, 1'b0, tlo);
        check("timeout_err", 32'(err), 32'd1);
        do_write(1'b1, 8'h33, 5, 5, 1'b0, tlo);
        check("err_sticky", 32'(err), 32'd1);

        // Reset in WAIT_LO of a user write.
        do_write(1'b1, 8'hA5, 5, 5, 1'b1, tlo);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_outputs", {req_ready, init_done, err, xfer_send, xfer_nibble, xfer_rs, xfer_delay},
              32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        c0 = cyc;
        run_init(c0);
        check("reinit_err", 32'(err), 32'd0);
        do_write(1'b1, 8'h7E, 5, 5, 1'b0, tlo);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/lcd_sequencer.md
# lcd_sequencer

Byte-level command/data sequencer for the 4-bit HD44780-style LCD path. After reset it runs the power-up initialisation sequence, then accepts byte writes (command or data) from a single requester. It splits each byte into high/low nibbles and issues them one at a time to the nibble transfer block via a send/done handshake. It also enforces every post-command execution delay, so the requester only ever sees a ready/valid interface.

## Interface
- FREQ, 50000000: clock frequency in Hz; T1US = FREQ/1000000 cycles per µs.
- POWERUP_US, 20000: wait after reset before the first init nibble.
- XFER_TIMEOUT_US, 1000: maximum wait for xfer_done per nibble.

Ports:
- CLK  in  1  system clock. One clock domain. Reset is asynchronous and active-high.
- RST  in  1  asynchronous, active-high reset.
- req_valid  in  1  requester has a byte.
- req_rs  in  1  0 = command, 1 = data.
- req_byte  in  8  byte to write.
- req_ready  out  1  sequencer can accept a byte this cycle.
- init_done  out  1  init sequence finished; stays 1 until reset.
- err  out  1  sticky; set on any xfer timeout.
- xfer_send  out  1  one-cycle start pulse to the transfer block.
- xfer_nibble  out  4  nibble to transfer.
- xfer_rs  out  1  RS for the nibble.
- xfer_delay  out  21  execution delay of the current step, in cycles (informational to the transfer block).
- xfer_done  in  1  one-cycle completion pulse from the transfer block.

## Operation
- Reset values:
  - req_ready=0, init_done=0, err=0, xfer_send=0, xfer_nibble=0, xfer_rs=0, xfer_delay=0.
  - State = PWR_WAIT; step index = 0; counter = 0.
- States: PWR_WAIT, LOAD, SEND_HI, WAIT_HI, GAP, SEND_LO, WAIT_LO, POST, IDLE.
- Init ROM, 8 steps of (byte, rs=0, single-nibble flag, delay µs):
  - Single-nibble steps (upper nibble only): 0x30/4100, 0x30/100, 0x30/100, 0x20/100.
  - Full-byte steps: 0x28/50, 0x0C/50, 0x01/2000, 0x06/50.
- PWR_WAIT: count POWERUP_US*T1US cycles, then go to LOAD with step 0.
- LOAD: latch the byte, rs and delay for the current step, then go to SEND_HI.
- SEND_HI: drive xfer_nibble=byte[7:4] and xfer_rs; pulse xfer_send; go to WAIT_HI.
- WAIT_HI on xfer_done: single-nibble step goes to POST; otherwise goes to GAP.
- GAP: T1US cycles, then SEND_LO.
- SEND_LO: drive xfer_nibble=byte[3:0]; pulse xfer_send; go to WAIT_LO.
- WAIT_LO on xfer_done: go to POST.
- POST: count delay_us*T1US cycles. Then:
  - during init, step 7 sets init_done and goes to IDLE;
  - other init steps increment the step index and go to LOAD;
  - user writes go to IDLE.
- IDLE: req_ready=1. When req_valid & req_ready, latch req_byte/req_rs and go to SEND_HI.
- User delay:
  - 2000 µs if req_rs=0 and req_byte is 0x01 (clear) or 0x02/0x03 (home);
  - 50 µs otherwise, including data bytes with value 0x01.
- xfer_nibble, xfer_rs and xfer_delay are held stable from xfer_send until the matching xfer_done.
- Timeout: in WAIT_HI/WAIT_LO, if xfer_done is absent for XFER_TIMEOUT_US*T1US cycles, set err and proceed exactly as if done had arrived.
- xfer_done outside WAIT_HI/WAIT_LO is ignored.
- xfer_done arriving in the same cycle the timeout expires: treated as done; err is not set.
- req_valid while req_ready=0 is ignored (no latching).
- RST asserted in any state: all outputs return to reset values immediately; init reruns from PWR_WAIT.

## Timing
- All outputs are registered.
- Accept at edge N (req_valid & req_ready): req_ready=0 from N+1; xfer_send=1 for the cycle after N+1 (LOAD bypassed, SEND_HI).
- xfer_done seen in cycle M (WAIT_HI): GAP occupies T1US cycles; the SEND_LO pulse follows in the next cycle.
- After the final xfer_done of a step, POST lasts exactly delay*T1US cycles; req_ready (or the next init send) follows in the next cycle.
- xfer_send is never high for two consecutive cycles.
- Counter is 24 bits, cleared on every state entry. No wrap is possible: the maximum count of 1,000,000 at default parameters fits.

## Test plan
All scenarios use FREQ=1000000 (T1US=1) and POWERUP_US=20000. The bench model returns xfer_done 5 cycles after xfer_send.
- Release RST -> no xfer_send for 20000 cycles; then nibbles 3,3,3,2 at rs=0 with gaps of 4100/100/100/100 cycles; then 2,8,0,C,0,1,0,6; init_done rises 50 cycles after the last done.
- After init, write 0x41 with rs=1 -> nibbles 4 then 1, both with xfer_rs=1; req_ready returns 50 cycles after the second done.
- Write 0x01 with rs=0 -> POST lasts 2000 cycles. Write 0x01 with rs=1 -> POST lasts 50 cycles.
- Hold req_valid=1 with 0x80 throughout init -> not accepted before init_done; accepted exactly once in the first IDLE cycle.
- Model withholds xfer_done for one nibble -> timeout after 1000 cycles, err=1 and stays 1, sequence completes normally.
- Pulse RST during WAIT_LO of a user write -> all outputs read their reset values, PWR_WAIT restarts, and the full init sequence reappears.
